// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared constants for the VeSPA branch resolver:
//   - bus and condition-code widths
//   - branch condition encodings (COND_BRA .. COND_BMI, 14/15 reserved)
//   - condition-code bit positions within {C,Z,N,V}
//   - resolver state encoding
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

   localparam int BUS_MSB    = 31;
   localparam int BUS_W      = BUS_MSB + 1;
   localparam int CCODES_MSB = 3;

   // Condition-code bit positions: bit3=C, bit2=Z, bit1=N, bit0=V
   localparam int CC_C = 3;
   localparam int CC_Z = 2;
   localparam int CC_N = 1;
   localparam int CC_V = 0;

   typedef enum logic [3:0] {
      COND_BRA  = 4'd0,
      COND_BNV  = 4'd1,
      COND_BCC  = 4'd2,
      COND_BCS  = 4'd3,
      COND_BVC  = 4'd4,
      COND_BVS  = 4'd5,
      COND_BEQ  = 4'd6,
      COND_BNE  = 4'd7,
      COND_BGE  = 4'd8,
      COND_BLT  = 4'd9,
      COND_BGT  = 4'd10,
      COND_BLE  = 4'd11,
      COND_BPL  = 4'd12,
      COND_BMI  = 4'd13,
      COND_RSV0 = 4'd14,
      COND_RSV1 = 4'd15
   } cond_e;

   typedef enum logic [1:0] {
      BR_IDLE    = 2'd0,
      BR_WAIT_CC = 2'd1,
      BR_RESOLVE = 2'd2,
      BR_FLUSH   = 2'd3
   } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator, shared with the VM model
// checker.
// Ports:
//   cond    [3:0]            branch condition field
//   codes   [CCODES_MSB:0]   condition codes {C,Z,N,V}
//   taken                    branch condition holds
//   illegal                  cond is a reserved encoding (never taken)
// -----------------------------------------------------------------------------
module branch_cond_eval
   import branch_resolver_pkg::*;
(
   input  logic [3:0]          cond,
   input  logic [CCODES_MSB:0] codes,
   output logic                taken,
   output logic                illegal
);

   logic c_s;
   logic z_s;
   logic n_s;
   logic v_s;
   logic lt_s;

   // Decode the condition field against the current condition codes
   always_comb begin
      c_s     = codes[CC_C];
      z_s     = codes[CC_Z];
      n_s     = codes[CC_N];
      v_s     = codes[CC_V];
      // signed less-than as seen by the ALU flags
      lt_s    = n_s ^ v_s;
      taken   = 1'b0;
      illegal = 1'b0;
      case (cond)
         COND_BRA: taken = 1'b1;
         COND_BNV: taken = 1'b0;
         COND_BCC: taken = ~c_s;
         COND_BCS: taken = c_s;
         COND_BVC: taken = ~v_s;
         COND_BVS: taken = v_s;
         COND_BEQ: taken = z_s;
         COND_BNE: taken = ~z_s;
         COND_BGE: taken = ~lt_s;
         COND_BLT: taken = lt_s;
         COND_BGT: taken = ~(z_s | lt_s);
         COND_BLE: taken = z_s | lt_s;
         COND_BPL: taken = ~n_s;
         COND_BMI: taken = n_s;
         default: begin
            taken   = 1'b0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Resolves VeSPA conditional branches. Accepts a request from decode over a
// valid/ready handshake, waits out pending condition-code updates, evaluates
// the condition against the live codes, pulses a redirect to fetch when taken
// and then blocks new requests for FLUSH_CYCLES cycles.
//
// Optional feature: define BRANCH_RESOLVER_STATS_EN to add saturating 16-bit
// taken / not-taken counters and a synchronous clear input.
//
// Ports:
//   i_Clk           clock, rising edge
//   i_Rst           asynchronous active-low reset
//   i_ReqValid      branch request valid
//   o_ReqReady      request can be accepted (IDLE only)
//   i_Cond          condition field
//   i_PC            address of the instruction after the branch
//   i_Disp          signed displacement
//   i_CondCodes     {C,Z,N,V}
//   i_CCPending     an in-flight ALU op will update the codes later
//   o_Redirect      one-cycle pulse, branch taken
//   o_Target        redirect address, holds last value otherwise
//   o_Resolved      one-cycle pulse on every resolution
//   o_IllegalCond   one-cycle pulse with o_Resolved for reserved conds
//   o_Flushing      high while in FLUSH
//   i_StatsClr      (stats build) synchronous counter clear
//   o_TakenCount    (stats build) taken resolutions, saturating
//   o_NotTakenCount (stats build) not-taken resolutions, saturating
// -----------------------------------------------------------------------------
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int DISP_W       = 23
)(
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_ReqValid,
   output logic                  o_ReqReady,
   input  logic [3:0]            i_Cond,
   input  logic [BUS_MSB:0]      i_PC,
   input  logic [DISP_W-1:0]     i_Disp,
   input  logic [CCODES_MSB:0]   i_CondCodes,
   input  logic                  i_CCPending,
   output logic                  o_Redirect,
   output logic [BUS_MSB:0]      o_Target,
   output logic                  o_Resolved,
   output logic                  o_IllegalCond,
   output logic                  o_Flushing
`ifdef BRANCH_RESOLVER_STATS_EN
   ,
   input  logic                  i_StatsClr,
   output logic [15:0]           o_TakenCount,
   output logic [15:0]           o_NotTakenCount
`endif
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   br_state_e        state_r;
   logic [3:0]       cond_r;
   logic [BUS_MSB:0] target_r;       // target computed at accept
   logic [BUS_MSB:0] target_hold_r;  // last redirected target
   logic [3:0]       flush_cnt_r;
   logic             ready_r;
   logic             flushing_r;

   logic             accept_s;
   logic             taken_s;
   logic             illegal_s;
   logic             in_resolve_s;
   logic             redirect_s;
   logic [BUS_MSB:0] disp_ext_s;

   branch_cond_eval u_cond_eval (
      .cond    (cond_r),
      .codes   (i_CondCodes),
      .taken   (taken_s),
      .illegal (illegal_s)
   );

   // Handshake and sign extension of the displacement to bus width
   always_comb begin
      accept_s   = i_ReqValid & ready_r;
      disp_ext_s = {{(BUS_W-DISP_W){i_Disp[DISP_W-1]}}, i_Disp};
   end

   // Resolution pulses: codes are only authoritative in the RESOLVE cycle
   always_comb begin
      in_resolve_s  = (state_r == BR_RESOLVE);
      redirect_s    = in_resolve_s & taken_s;
      o_Resolved    = in_resolve_s;
      o_Redirect    = redirect_s;
      o_IllegalCond = in_resolve_s & illegal_s;
      if (redirect_s) begin
         o_Target = target_r;
      end else begin
         o_Target = target_hold_r;
      end
      o_ReqReady = ready_r;
      o_Flushing = flushing_r;
   end

   // Resolver FSM; ready/flushing are registered from the next state so that
   // ready stays low throughout reset and rises on the first edge after it
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_r       <= BR_IDLE;
         cond_r        <= 4'd0;
         target_r      <= '0;
         target_hold_r <= '0;
         flush_cnt_r   <= 4'd0;
         ready_r       <= 1'b0;
         flushing_r    <= 1'b0;
      end else begin
         case (state_r)
            BR_IDLE: begin
               if (accept_s) begin
                  cond_r   <= i_Cond;
                  target_r <= i_PC + disp_ext_s;
                  ready_r  <= 1'b0;
                  // only the pending flag at the accept edge matters
                  if (i_CCPending) begin
                     state_r <= BR_WAIT_CC;
                  end else begin
                     state_r <= BR_RESOLVE;
                  end
               end else begin
                  ready_r <= 1'b1;
               end
            end
            BR_WAIT_CC: begin
               if (i_CCPending) begin
                  state_r <= BR_WAIT_CC;
               end else begin
                  state_r <= BR_RESOLVE;
               end
            end
            BR_RESOLVE: begin
               if (taken_s) begin
                  state_r       <= BR_FLUSH;
                  flush_cnt_r   <= FLUSH_LOAD;
                  flushing_r    <= 1'b1;
                  target_hold_r <= target_r;
               end else begin
                  state_r <= BR_IDLE;
                  ready_r <= 1'b1;
               end
            end
            BR_FLUSH: begin
               if (flush_cnt_r == 4'd0) begin
                  state_r    <= BR_IDLE;
                  flushing_r <= 1'b0;
                  ready_r    <= 1'b1;
               end else begin
                  flush_cnt_r <= flush_cnt_r - 4'd1;
               end
            end
            default: begin
               state_r    <= BR_IDLE;
               ready_r    <= 1'b0;
               flushing_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [15:0] taken_cnt_r;
   logic [15:0] not_taken_cnt_r;

   // Saturating resolution statistics; reserved conds count as not taken
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         taken_cnt_r     <= 16'd0;
         not_taken_cnt_r <= 16'd0;
      end else if (i_StatsClr) begin
         taken_cnt_r     <= 16'd0;
         not_taken_cnt_r <= 16'd0;
      end else if (in_resolve_s) begin
         if (taken_s) begin
            if (taken_cnt_r != 16'hFFFF) begin
               taken_cnt_r <= taken_cnt_r + 16'd1;
            end else begin
               taken_cnt_r <= taken_cnt_r;
            end
         end else begin
            if (not_taken_cnt_r != 16'hFFFF) begin
               not_taken_cnt_r <= not_taken_cnt_r + 16'd1;
            end else begin
               not_taken_cnt_r <= not_taken_cnt_r;
            end
         end
      end else begin
         taken_cnt_r     <= taken_cnt_r;
         not_taken_cnt_r <= not_taken_cnt_r;
      end
   end

   // Counter outputs
   always_comb begin
      o_TakenCount    = taken_cnt_r;
      o_NotTakenCount = not_taken_cnt_r;
   end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Directed-vector scoreboard bench for branch_resolver (default build).
// Stimulus pushes the hand-computed expected resolution into a queue; a
// monitor on the falling edge pops and compares whenever o_Resolved is high.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b0;
   logic        i_ReqValid = 1'b0;
   logic        o_ReqReady;
   logic [3:0]  i_Cond = 4'd0;
   logic [31:0] i_PC = 32'd0;
   logic [22:0] i_Disp = 23'd0;
   logic [3:0]  i_CondCodes = 4'd0;
   logic        i_CCPending = 1'b0;
   logic        o_Redirect;
   logic [31:0] o_Target;
   logic        o_Resolved;
   logic        o_IllegalCond;
   logic        o_Flushing;

   branch_resolver #(.FLUSH_CYCLES(2), .DISP_W(23)) dut (
      .i_Clk         (i_Clk),
      .i_Rst         (i_Rst),
      .i_ReqValid    (i_ReqValid),
      .o_ReqReady    (o_ReqReady),
      .i_Cond        (i_Cond),
      .i_PC          (i_PC),
      .i_Disp        (i_Disp),
      .i_CondCodes   (i_CondCodes),
      .i_CCPending   (i_CCPending),
      .o_Redirect    (o_Redirect),
      .o_Target      (o_Target),
      .o_Resolved    (o_Resolved),
      .o_IllegalCond (o_IllegalCond),
      .o_Flushing    (o_Flushing)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      int          id;
      logic        redirect;
      logic        illegal;
      logic [31:0] target;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge i_Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every resolution against the scoreboard head
   always @(negedge i_Clk) begin
      exp_t e;
      if (o_Resolved === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resolve: resolve at cycle %0d, expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d_cycle", e.id), cyc, e.cyc);
            chk($sformatf("v%0d_redirect", e.id), {31'd0, o_Redirect}, {31'd0, e.redirect});
            chk($sformatf("v%0d_illegal", e.id), {31'd0, o_IllegalCond}, {31'd0, e.illegal});
            chk($sformatf("v%0d_target", e.id), o_Target, e.target);
         end
      end else begin
         chk("stray_pulse", {30'd0, o_Redirect, o_IllegalCond}, 32'd0);
      end
   end

   // Issue one request; p = cycles i_CCPending is sampled high from the accept
   // edge on. cc0 is presented first, cc1 from the last pending cycle.
   task automatic issue(input int id, input logic [3:0] cond, input logic [31:0] pc,
                        input logic [22:0] disp, input logic [3:0] cc0,
                        input logic [3:0] cc1, input int p, input logic exp_red,
                        input logic exp_ill, input logic [31:0] exp_tgt);
      exp_t e;
      int   n = 0;
      while (o_ReqReady !== 1'b1 && n < 50) begin
         @(posedge i_Clk); #2;
         n++;
      end
      if (o_ReqReady !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL v%0d_ready_timeout: ready=%b expected 1", id, o_ReqReady);
         return;
      end
      i_ReqValid  = 1'b1;
      i_Cond      = cond;
      i_PC        = pc;
      i_Disp      = disp;
      i_CondCodes = (p >= 2) ? cc0 : cc1;
      i_CCPending = (p > 0);
      e.id       = id;
      e.redirect = exp_red;
      e.illegal  = exp_ill;
      e.target   = exp_tgt;
      e.cyc      = cyc + 1 + p;
      sb_q.push_back(e);
      @(posedge i_Clk); #2;
      // scramble request fields so only latched values can matter
      i_ReqValid = 1'b0;
      i_Cond     = 4'd1;
      i_PC       = 32'hDEADBEEF;
      i_Disp     = 23'h155555;
      if (p >= 2) begin
         repeat (p - 2) begin
            @(posedge i_Clk); #2;
         end
         i_CondCodes = cc1;
         @(posedge i_Clk); #2;
      end
      i_CCPending = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(posedge i_Clk);
      #2;
      chk("rst_ready", {31'd0, o_ReqReady}, 32'd0);
      chk("rst_flushing", {31'd0, o_Flushing}, 32'd0);
      chk("rst_resolved", {31'd0, o_Resolved}, 32'd0);
      chk("rst_target", o_Target, 32'd0);
      i_Rst = 1'b1;
      #1;
      chk("rel_ready_pre_edge", {31'd0, o_ReqReady}, 32'd0);
      @(posedge i_Clk); #2;
      chk("rel_ready_first_edge", {31'd0, o_ReqReady}, 32'd1);

      // BEQ taken, negative displacement, then flush window
      issue(1, 4'd6, 32'h100, 23'h7FFFFC, 4'b0100, 4'b0100, 0, 1'b1, 1'b0, 32'h0FC);
      @(posedge i_Clk); #2;
      chk("v1_flush1", {31'd0, o_Flushing}, 32'd1);
      chk("v1_flush1_ready", {31'd0, o_ReqReady}, 32'd0);
      @(posedge i_Clk); #2;
      chk("v1_flush2", {31'd0, o_Flushing}, 32'd1);
      @(posedge i_Clk); #2;
      chk("v1_flush_end", {31'd0, o_Flushing}, 32'd0);
      chk("v1_ready_back", {31'd0, o_ReqReady}, 32'd1);

      // BGE with N set: not taken, ready on the following cycle
      issue(2, 4'd8, 32'h200, 23'h10, 4'b0010, 4'b0010, 0, 1'b0, 1'b0, 32'h0FC);
      @(posedge i_Clk); #2;
      chk("v2_ready_next", {31'd0, o_ReqReady}, 32'd1);

      // BVS with 3 pending cycles, codes become V in the last pending cycle
      issue(3, 4'd5, 32'h1000, 23'h20, 4'b0000, 4'b0001, 3, 1'b1, 1'b0, 32'h1020);
      // reserved cond
      issue(4, 4'd14, 32'h300, 23'h4, 4'b1111, 4'b1111, 0, 1'b0, 1'b1, 32'h1020);
      // BRA with address wrap
      issue(5, 4'd0, 32'hFFFFFFFC, 23'h8, 4'b0000, 4'b0000, 0, 1'b1, 1'b0, 32'h4);
      issue(6, 4'd1, 32'h400, 23'h4, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 32'h4);
      issue(7, 4'd2, 32'h500, 23'h100, 4'b0000, 4'b0000, 0, 1'b1, 1'b0, 32'h600);
      issue(8, 4'd3, 32'h10, 23'h0, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 32'h600);
      issue(9, 4'd4, 32'h10, 23'h0, 4'b0001, 4'b0001, 0, 1'b0, 1'b0, 32'h600);
      issue(10, 4'd7, 32'h10, 23'h0, 4'b0100, 4'b0100, 0, 1'b0, 1'b0, 32'h600);
      issue(11, 4'd9, 32'h10, 23'h0, 4'b0011, 4'b0011, 0, 1'b0, 1'b0, 32'h600);
      issue(12, 4'd10, 32'h2000, 23'h7FFFF0, 4'b0000, 4'b0000, 0, 1'b1, 1'b0, 32'h1FF0);
      issue(13, 4'd11, 32'h3000, 23'h0, 4'b0001, 4'b0001, 0, 1'b1, 1'b0, 32'h3000);
      issue(14, 4'd12, 32'h10, 23'h0, 4'b0010, 4'b0010, 0, 1'b0, 1'b0, 32'h3000);
      issue(15, 4'd13, 32'h40, 23'h40, 4'b1010, 4'b1010, 0, 1'b1, 1'b0, 32'h80);
      issue(16, 4'd15, 32'h10, 23'h0, 4'b0000, 4'b0000, 0, 1'b0, 1'b1, 32'h80);
      // pending only at the accept edge: one WAIT_CC cycle
      issue(17, 4'd6, 32'h800, 23'h8, 4'b0100, 4'b0100, 1, 1'b1, 1'b0, 32'h808);
      issue(18, 4'd8, 32'h900, 23'h7FFFFF, 4'b1000, 4'b1000, 0, 1'b1, 1'b0, 32'h8FF);

      // asynchronous reset in the middle of FLUSH
      issue(19, 4'd0, 32'h50, 23'h0, 4'b0000, 4'b0000, 0, 1'b1, 1'b0, 32'h50);
      @(posedge i_Clk); #2;
      chk("v19_in_flush", {31'd0, o_Flushing}, 32'd1);
      #1 i_Rst = 1'b0;
      #1;
      chk("mid_rst_flushing", {31'd0, o_Flushing}, 32'd0);
      chk("mid_rst_ready", {31'd0, o_ReqReady}, 32'd0);
      chk("mid_rst_target", o_Target, 32'd0);
      chk("mid_rst_redirect", {31'd0, o_Redirect}, 32'd0);
      @(posedge i_Clk); #2;
      i_Rst = 1'b1;
      #1;
      chk("rerel_ready_pre_edge", {31'd0, o_ReqReady}, 32'd0);
      @(posedge i_Clk); #2;
      chk("rerel_ready_first_edge", {31'd0, o_ReqReady}, 32'd1);

      // normal operation after reset
      issue(20, 4'd7, 32'h60, 23'h4, 4'b0000, 4'b0000, 0, 1'b1, 1'b0, 32'h64);
      repeat (6) @(posedge i_Clk);
      #2;
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
